pulse_stretch_oneshot: RTL and testbench

//  Converts a single-cycle tick into a clean level pulse of fixed length, followed by an

---
 rtl/stretch_pkg.sv | 18 +
 rtl/stretch_down_counter.sv | 35 +++
 rtl/pulse_stretch_oneshot.sv | 119 +++++++++++
 tb/tb_pulse_stretch_oneshot.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/stretch_pkg.sv
// Shared types and sizing helper for the pulse stretcher.
package stretch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    GAP  = 2'd2
  } stretch_state_t;

  // Counter must hold PULSE_LEN-1 and GAP_LEN-1; never narrower than one bit.
  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    if (m < 2) m = 2;
    return $clog2(m);
  endfunction

endpackage

// File: rtl/stretch_down_counter.sv
// Loadable down-counter that stops at zero; one instance times both HIGH and GAP phases.
module stretch_down_counter #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         zero
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/pulse_stretch_oneshot.sv
// Tick-to-level one-shot: PULSE_LEN cycles high, then GAP_LEN cycles forced low.
// Define STRETCH_RETRIGGER_EN to let a tick during HIGH restart the pulse instead of dropping.
module pulse_stretch_oneshot
  import stretch_pkg::*;
#(
  parameter int PULSE_LEN = 4,
  parameter int GAP_LEN   = 2,
  parameter int DCNT_W    = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tick,
  output logic              level,
  output logic              busy,
  output logic              drop,
  output logic [DCNT_W-1:0] drop_cnt
);

  localparam int CW = cnt_width(PULSE_LEN, GAP_LEN);
  localparam logic [CW-1:0] PULSE_LOAD = CW'(PULSE_LEN - 1);
  localparam logic [CW-1:0] GAP_LOAD = CW'((GAP_LEN > 0) ? (GAP_LEN - 1) : 0);
  localparam logic [DCNT_W-1:0] DCNT_MAX = '1;

  stretch_state_t    state_q;
  stretch_state_t    state_d;
  logic              cnt_load;
  logic [CW-1:0]     cnt_load_val;
  logic              cnt_en;
  logic              cnt_zero;
  logic              ignored;
  logic              level_q;
  logic              busy_q;
  logic              drop_q;
  logic [DCNT_W-1:0] drop_cnt_q;

  stretch_down_counter #(.W(CW)) u_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .en       (cnt_en),
    .zero     (cnt_zero)
  );

  always_comb begin
    state_d      = state_q;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    cnt_en       = 1'b0;
    ignored      = 1'b0;
    case (state_q)
      IDLE: begin
        if (tick) begin
          state_d      = HIGH;
          cnt_load     = 1'b1;
          cnt_load_val = PULSE_LOAD;
        end
      end
      HIGH: begin
        if (!cnt_zero) begin
          cnt_en = 1'b1;
        end else if (GAP_LEN > 0) begin
          state_d      = GAP;
          cnt_load     = 1'b1;
          cnt_load_val = GAP_LOAD;
        end else begin
          state_d = IDLE;
        end
`ifdef STRETCH_RETRIGGER_EN
        // A fresh tick overrides the end-of-pulse decision, even on the last HIGH cycle.
        if (tick) begin
          state_d      = HIGH;
          cnt_load     = 1'b1;
          cnt_load_val = PULSE_LOAD;
          cnt_en       = 1'b0;
        end
`else
        ignored = tick;
`endif
      end
      GAP: begin
        ignored = tick;
        if (!cnt_zero) begin
          cnt_en = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      level_q    <= 1'b0;
      busy_q     <= 1'b0;
      drop_q     <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      level_q <= (state_d == HIGH);
      busy_q  <= (state_d != IDLE);
      drop_q  <= ignored;
      if (ignored && (drop_cnt_q != DCNT_MAX)) begin
        drop_cnt_q <= drop_cnt_q + DCNT_W'(1);
      end
    end
  end

  assign level    = level_q;
  assign busy     = busy_q;
  assign drop     = drop_q;
  assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_pulse_stretch_oneshot.sv
// Self-checking bench for pulse_stretch_oneshot: vector table, corner sequences, random vs model.
module tb_pulse_stretch_oneshot;

  localparam int P = 4;
  localparam int G = 2;
  localparam int DW = 8;
  localparam int DMAX = (1 << DW) - 1;
  localparam int NV = 48;

  logic          clk = 1'b0;
  logic          reset, tick;
  logic          level, busy, drop;
  logic [DW-1:0] drop_cnt;
  logic          reset0, tick0;
  logic          level0, busy0, drop0;
  logic [DW-1:0] drop_cnt0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pulse_stretch_oneshot #(.PULSE_LEN(P), .GAP_LEN(G), .DCNT_W(DW)) u_dut (
    .clk      (clk),
    .reset    (reset),
    .tick     (tick),
    .level    (level),
    .busy     (busy),
    .drop     (drop),
    .drop_cnt (drop_cnt)
  );

  pulse_stretch_oneshot #(.PULSE_LEN(P), .GAP_LEN(0), .DCNT_W(DW)) u_dut0 (
    .clk      (clk),
    .reset    (reset0),
    .tick     (tick0),
    .level    (level0),
    .busy     (busy0),
    .drop     (drop0),
    .drop_cnt (drop_cnt0)
  );

  typedef struct {
    bit rst;
    bit tk;
    bit lvl;
    bit bsy;
    bit drp;
    int cnt;
  } vec_t;

  vec_t vec [NV];

  task automatic check(input string name, input int idx, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s @%0d: got %0d, expected %0d", name, idx, act, exp);
    end
  endtask

  // Reference model: pulse windows tracked as cycle numbers.
  int m_n, m_start, m_hi_end, m_cnt;
  bit m_drop;

  task automatic model_reset();
    m_start  = -1000;
    m_hi_end = -1000;
    m_drop   = 1'b0;
    m_cnt    = 0;
  endtask

  function automatic bit m_in_high(input int c);
    return (c >= m_start + 1) && (c <= m_hi_end);
  endfunction

  function automatic bit m_in_busy(input int c);
    return (c >= m_start + 1) && (c <= m_hi_end + G);
  endfunction

  task automatic model_drop();
    m_drop = 1'b1;
    if (m_cnt < DMAX) m_cnt++;
  endtask

  task automatic model_step(input bit rst, input bit tk);
    if (rst) begin
      model_reset();
    end else begin
      m_drop = 1'b0;
      if (tk) begin
        if (m_in_high(m_n)) begin
`ifdef STRETCH_RETRIGGER_EN
          m_hi_end = m_n + P;
`else
          model_drop();
`endif
        end else if (m_in_busy(m_n)) begin
          model_drop();
        end else begin
          m_start  = m_n;
          m_hi_end = m_n + P;
        end
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int dexp;
    bit rr, tt;

    reset = 1'b1; tick = 1'b0; reset0 = 1'b1; tick0 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_level", 0, level, 0);
    check("rst_busy", 0, busy, 0);
    check("rst_drop", 0, drop, 0);
    check("rst_drop_cnt", 0, drop_cnt, 0);

    // Vector table: single pulse, tick in GAP, tick in HIGH, reset mid-pulse.
    for (int i = 0; i < NV; i++) vec[i] = '{0, 0, 0, 0, 0, 0};
    vec[2].tk = 1;
    for (int i = 3; i <= 6; i++) vec[i].lvl = 1;
    for (int i = 3; i <= 8; i++) vec[i].bsy = 1;
    vec[12].tk = 1; vec[17].tk = 1;
    for (int i = 13; i <= 16; i++) vec[i].lvl = 1;
    for (int i = 13; i <= 18; i++) vec[i].bsy = 1;
    vec[18].drp = 1;
    for (int i = 18; i <= 38; i++) vec[i].cnt = 1;
    vec[24].tk = 1; vec[26].tk = 1;
`ifdef STRETCH_RETRIGGER_EN
    for (int i = 25; i <= 30; i++) vec[i].lvl = 1;
    for (int i = 25; i <= 32; i++) vec[i].bsy = 1;
`else
    for (int i = 25; i <= 28; i++) vec[i].lvl = 1;
    for (int i = 25; i <= 30; i++) vec[i].bsy = 1;
    vec[27].drp = 1;
    for (int i = 27; i <= 38; i++) vec[i].cnt = 2;
`endif
    vec[36].tk = 1; vec[38].rst = 1;
    for (int i = 37; i <= 38; i++) begin vec[i].lvl = 1; vec[i].bsy = 1; end
    vec[39].tk = 1;
    for (int i = 40; i <= 43; i++) vec[i].lvl = 1;
    for (int i = 40; i <= 45; i++) vec[i].bsy = 1;

    for (int i = 0; i < NV; i++) begin
      @(posedge clk); #1;
      reset = vec[i].rst; tick = vec[i].tk;
      @(negedge clk);
      check("vec_level", i, level, int'(vec[i].lvl));
      check("vec_busy", i, busy, int'(vec[i].bsy));
      check("vec_drop", i, drop, int'(vec[i].drp));
      check("vec_drop_cnt", i, drop_cnt, vec[i].cnt);
      $display("[TB] vec %0d rst=%0d tick=%0d level=%0d busy=%0d drop=%0d cnt=%0d",
               i, vec[i].rst, vec[i].tk, level, busy, drop, drop_cnt);
    end

`ifndef STRETCH_RETRIGGER_EN
    // Tick every cycle: 7-cycle period, drop counter saturates.
    @(posedge clk); #1; reset = 1'b1; tick = 1'b0;
    for (int c = 0; c < 320; c++) begin
      @(posedge clk); #1;
      reset = 1'b0; tick = 1'b1;
      @(negedge clk);
      dexp = c - (c + 6) / 7;
      if (dexp > DMAX) dexp = DMAX;
      check("flood_level", c, level, int'((c >= 1) && ((c - 1) % 7 < 4)));
      check("flood_drop", c, drop, int'((c >= 1) && ((c - 1) % 7 != 0)));
      check("flood_drop_cnt", c, drop_cnt, dexp);
    end
    $display("[TB] flood done drop_cnt=%0d", drop_cnt);
`endif

    // GAP_LEN=0 instance: tick on the final HIGH cycle is dropped.
    @(posedge clk); #1; reset = 1'b1; tick = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      reset0 = 1'b0; tick0 = (c == 0) || (c == 4) || (c == 5);
      @(negedge clk);
      check("gap0_level", c, level0, int'(((c >= 1) && (c <= 4)) || ((c >= 6) && (c <= 9))));
      check("gap0_busy", c, busy0, int'(((c >= 1) && (c <= 4)) || ((c >= 6) && (c <= 9))));
      check("gap0_drop", c, drop0, int'(c == 5));
      check("gap0_drop_cnt", c, drop_cnt0, (c >= 5) ? 1 : 0);
      $display("[TB] gap0 %0d tick=%0d level=%0d drop=%0d", c, tick0, level0, drop0);
    end
    @(posedge clk); #1; reset0 = 1'b1; tick0 = 1'b0;

    // Randomized run against the reference model.
    reset = 1'b1; tick = 1'b0;
    @(posedge clk); #1;
    model_reset();
    m_n = 0;
    for (int c = 0; c < 3000; c++) begin
      rr = ($urandom_range(0, 199) == 0);
      tt = ($urandom_range(0, 99) < 35);
      reset = rr; tick = tt;
      @(negedge clk);
      check("rand_level", c, level, int'(m_in_high(m_n)));
      check("rand_busy", c, busy, int'(m_in_busy(m_n)));
      check("rand_drop", c, drop, int'(m_drop));
      check("rand_drop_cnt", c, drop_cnt, m_cnt);
      model_step(rr, tt);
      m_n++;
      @(posedge clk); #1;
    end
    $display("[TB] random done drop_cnt=%0d", drop_cnt);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
